engine_ctrl: RTL and testbench

Sequencer for the streaming convolution engine. It gates the upstream weight and image streams into the engine, so a full kernel (KERNEL_WIDTH*KERNEL_HEIGHT weights) is loaded before any image beat is issued. It counts the image beats of one pass and regenerates the result-valid strobe that the engine does not provide. It sits between the input DMA/line-buffer and the engine, with the result FIFO downstream.

---
 rtl/engine_pkg.sv | 20 ++
 rtl/engine_ctrl_valid_pipe.sv | 46 ++++
 rtl/engine_ctrl.sv | 133 +++++++++++++
 tb/tb_engine_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/engine_pkg.sv
// engine_pkg: shared types and constants for the convolution engine sequencer.
//   ctrl_state_t : sequencer states (IDLE, LOAD, RUN, DRAIN)
//   KERNEL_NB    : weights per kernel for the default 3x3 kernel
//   kernel_nb()  : weights per kernel for any kernel geometry
package engine_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } ctrl_state_t;

  localparam int KERNEL_NB = 3 * 3;

  function automatic int kernel_nb(input int kw, input int kh);
    return kw * kh;
  endfunction

endpackage

// File: rtl/engine_ctrl_valid_pipe.sv
// valid_pipe: fixed-depth shift line that regenerates the engine result strobe.
//   clk     : clock
//   rst     : synchronous active-low reset, clears the whole line
//   strobe  : engine image strobe entering the line
//   delayed : strobe delayed by exactly DEPTH cycles (result valid)
//   empty   : no pulse is held behind the output stage, i.e. after this
//             cycle the line carries nothing
module valid_pipe #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic delayed,
  output logic empty
);

  logic [DEPTH-1:0] line_reg;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk) begin
        if (!rst) begin
          line_reg <= '0;
        end else begin
          line_reg <= strobe;
        end
      end
      assign empty = 1'b1;
    end else begin : g_multi
      always_ff @(posedge clk) begin
        if (!rst) begin
          line_reg <= '0;
        end else begin
          line_reg <= {line_reg[DEPTH-2:0], strobe};
        end
      end
      // The output stage is excluded so that done can coincide with the
      // last result leaving the line.
      assign empty = ~|line_reg[DEPTH-2:0];
    end
  endgenerate

  assign delayed = line_reg[DEPTH-1];

endmodule

// File: rtl/engine_ctrl.sv
// engine_ctrl: sequencer gating weight and image streams into the
// convolution engine and regenerating its result-valid strobe.
//   clk, rst                 : clock, synchronous active-low reset
//   start, cfg_reload,
//   cfg_beats                : pass request and its configuration
//   up_weight*, up_image*    : upstream weight / image handshakes
//   dn_afull                 : result FIFO almost-full back-pressure
//   eng_weight*, eng_image_valid : engine-side strobes
//   result_valid             : engine result valid this cycle
//   busy, done               : pass status
module engine_ctrl
  import engine_pkg::*;
#(
  parameter int WEIGHT_WIDTH  = 8,
  parameter int KERNEL_WIDTH  = 3,
  parameter int KERNEL_HEIGHT = 3,
  parameter int PIPE_LATENCY  = 4,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    cfg_reload,
  input  logic [COUNT_WIDTH-1:0]  cfg_beats,
  input  logic [WEIGHT_WIDTH-1:0] up_weight,
  input  logic                    up_weight_valid,
  output logic                    up_weight_ready,
  input  logic                    up_image_valid,
  output logic                    up_image_ready,
  input  logic                    dn_afull,
  output logic [WEIGHT_WIDTH-1:0] eng_weight,
  output logic                    eng_weight_valid,
  output logic                    eng_image_valid,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int NB = kernel_nb(KERNEL_WIDTH, KERNEL_HEIGHT);
  localparam int WCNT_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(NB - 1);

  ctrl_state_t            state_reg, state_next;
  logic [WCNT_W-1:0]      wcnt_reg, wcnt_next;
  logic [COUNT_WIDTH-1:0] beats_reg, beats_next;
  // High when the previous cycle was already DRAIN: DRAIN always lasts at
  // least one cycle before done, even with an empty line.
  logic                   dwell_reg;
  logic                   pipe_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      wcnt_reg  <= '0;
      beats_reg <= '0;
      dwell_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      wcnt_reg  <= wcnt_next;
      beats_reg <= beats_next;
      dwell_reg <= (state_reg == DRAIN);
    end
  end

  always_comb begin
    state_next       = state_reg;
    wcnt_next        = wcnt_reg;
    beats_next       = beats_reg;
    up_weight_ready  = 1'b0;
    up_image_ready   = 1'b0;
    eng_weight_valid = 1'b0;
    eng_image_valid  = 1'b0;
    done             = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          beats_next = cfg_beats;
          if (cfg_reload) begin
            state_next = LOAD;
          end else if (cfg_beats == '0) begin
            state_next = DRAIN;
          end else begin
            state_next = RUN;
          end
        end
      end
      LOAD: begin
        up_weight_ready = 1'b1;
        if (up_weight_valid) begin
          eng_weight_valid = 1'b1;
          if (wcnt_reg == WCNT_LAST) begin
            // Exactly NB strobes: the engine token ring is back home.
            wcnt_next  = '0;
            state_next = (beats_reg == '0) ? DRAIN : RUN;
          end else begin
            wcnt_next = wcnt_reg + WCNT_W'(1);
          end
        end
      end
      RUN: begin
        up_image_ready = !dn_afull;
        if (up_image_valid && !dn_afull) begin
          eng_image_valid = 1'b1;
          beats_next      = beats_reg - COUNT_WIDTH'(1);
          if (beats_reg == COUNT_WIDTH'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (dwell_reg && pipe_empty) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy       = (state_reg != IDLE);
  assign eng_weight = up_weight;

  valid_pipe #(
    .DEPTH(PIPE_LATENCY)
  ) u_valid_pipe (
    .clk    (clk),
    .rst    (rst),
    .strobe (eng_image_valid),
    .delayed(result_valid),
    .empty  (pipe_empty)
  );

endmodule

// File: tb/tb_engine_ctrl.sv
// tb_engine_ctrl: randomized self-checking bench for engine_ctrl with a
// cycle-level behavioural model (phase + counts + queue of image fire times).
module tb_engine_ctrl;

  localparam int WW = 8;
  localparam int KW = 3;
  localparam int KH = 3;
  localparam int L  = 4;
  localparam int CW = 16;
  localparam int NBW = KW * KH;

  localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2, P_DRAIN = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          cfg_reload;
  logic [CW-1:0] cfg_beats;
  logic [WW-1:0] up_weight;
  logic          up_weight_valid;
  logic          up_weight_ready;
  logic          up_image_valid;
  logic          up_image_ready;
  logic          dn_afull;
  logic [WW-1:0] eng_weight;
  logic          eng_weight_valid;
  logic          eng_image_valid;
  logic          result_valid;
  logic          busy;
  logic          done;

  engine_ctrl #(
    .WEIGHT_WIDTH (WW),
    .KERNEL_WIDTH (KW),
    .KERNEL_HEIGHT(KH),
    .PIPE_LATENCY (L),
    .COUNT_WIDTH  (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .cfg_reload      (cfg_reload),
    .cfg_beats       (cfg_beats),
    .up_weight       (up_weight),
    .up_weight_valid (up_weight_valid),
    .up_weight_ready (up_weight_ready),
    .up_image_valid  (up_image_valid),
    .up_image_ready  (up_image_ready),
    .dn_afull        (dn_afull),
    .eng_weight      (eng_weight),
    .eng_weight_valid(eng_weight_valid),
    .eng_image_valid (eng_image_valid),
    .result_valid    (result_valid),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  // Observed event counters (written only by the compare process).
  int n_w = 0, n_i = 0, n_r = 0, n_done = 0;
  int done_cyc = -1, last_if = -1;

  // Behavioural model state (written only by the compare process).
  int ph = P_IDLE;
  int weights_left = 0;
  int images_left = 0;
  int done_at = -1;
  int pass_last_fire = -1;
  int fq[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int  e_busy, e_wr, e_wv, e_ir, e_iv, e_rv, e_done, e_start;
    if (check_en) begin
      e_busy = (ph != P_IDLE);
      e_wr   = (ph == P_LOAD);
      e_wv   = e_wr && up_weight_valid;
      e_ir   = (ph == P_RUN) && !dn_afull;
      e_iv   = e_ir && up_image_valid;
      e_rv   = (fq.size() > 0) && (fq[0] == cyc - L);
      e_done = (ph == P_DRAIN) && (cyc == done_at);
      check("busy", busy, e_busy);
      check("up_weight_ready", up_weight_ready, e_wr);
      check("eng_weight_valid", eng_weight_valid, e_wv);
      check("eng_weight", eng_weight, up_weight);
      check("up_image_ready", up_image_ready, e_ir);
      check("eng_image_valid", eng_image_valid, e_iv);
      check("result_valid", result_valid, e_rv);
      check("done", done, e_done);
      if (eng_weight_valid) n_w++;
      if (eng_image_valid) begin n_i++; last_if = cyc; end
      if (result_valid) n_r++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (e_rv) void'(fq.pop_front());

      // Advance the model to the next cycle.
      if (!rst) begin
        ph = P_IDLE;
        fq.delete();
      end else begin
        e_start = 0;
        case (ph)
          P_IDLE: if (start) begin
            images_left = cfg_beats;
            pass_last_fire = -1;
            e_start = 1;
          end
          P_LOAD: if (e_wv) begin
            weights_left--;
            if (weights_left == 0) begin
              if (images_left == 0) begin
                ph = P_DRAIN; done_at = cyc + 2;
              end else ph = P_RUN;
            end
          end
          P_RUN: if (e_iv) begin
            fq.push_back(cyc);
            pass_last_fire = cyc;
            images_left--;
            if (images_left == 0) begin
              ph = P_DRAIN;
              done_at = (cyc + L > cyc + 2) ? cyc + L : cyc + 2;
            end
          end
          P_DRAIN: if (cyc == done_at) ph = P_IDLE;
          default: ph = P_IDLE;
        endcase
        if (e_start) begin
          if (cfg_reload) begin
            ph = P_LOAD; weights_left = NBW;
          end else if (cfg_beats == 0) begin
            ph = P_DRAIN; done_at = cyc + 2;
          end else ph = P_RUN;
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_pass(input bit reload, input int beats, input int wmod,
                         input int iprob, input int aprob, input bit poke);
    int s_cyc, w0, i0, r0, d0, k;
    bit seen;
    w0 = n_w; i0 = n_i; r0 = n_r; d0 = n_done;
    start = 1'b1; cfg_reload = reload; cfg_beats = CW'(beats);
    up_weight_valid = 1'b0; up_image_valid = 1'b0; dn_afull = 1'b0;
    s_cyc = cyc;
    step();
    start = 1'b0;
    cfg_reload = 1'(~reload); cfg_beats = CW'($urandom_range(0, 50));
    check("busy_after_start", busy, 1);
    seen = 1'b0;
    k = 0;
    while (!seen && k < 400) begin
      up_weight       = WW'($urandom);
      up_weight_valid = (k % wmod == 0);
      up_image_valid  = ($urandom_range(0, 99) < iprob);
      dn_afull        = ($urandom_range(0, 99) < aprob);
      start           = poke && ($urandom_range(0, 99) < 20);
      cfg_reload      = 1'($urandom);
      cfg_beats       = CW'($urandom_range(0, 50));
      step();
      start = 1'b0;
      seen = (n_done != d0);
      k++;
    end
    check("pass_timeout", seen, 1);
    up_weight_valid = 1'b0; up_image_valid = 1'b0; dn_afull = 1'b0;
    check("weight_strobes", n_w - w0, reload ? NBW : 0);
    check("image_strobes", n_i - i0, beats);
    check("result_pulses", n_r - r0, beats);
    check("done_pulses", n_done - d0, 1);
    check("busy_after_done", busy, 0);
    if (beats > 0) check("done_after_last_image", done_cyc - last_if, L);
    else if (!reload) check("done_from_start", done_cyc - s_cyc, 2);
    $display("pass reload=%0d beats=%0d wmod=%0d iprob=%0d aprob=%0d cycles=%0d",
             reload, beats, wmod, iprob, aprob, k + 1);
    step();
  endtask

  initial begin
    int r0;
    rst = 1'b0; start = 1'b0; cfg_reload = 1'b0; cfg_beats = '0;
    up_weight = '0; up_weight_valid = 1'b0; up_image_valid = 1'b0; dn_afull = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_en = 1'b1;
    check("rst_busy", busy, 0);
    check("rst_up_weight_ready", up_weight_ready, 0);
    check("rst_up_image_ready", up_image_ready, 0);
    check("rst_eng_weight_valid", eng_weight_valid, 0);
    check("rst_eng_image_valid", eng_image_valid, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_done", done, 0);
    rst = 1'b1;
    step();

    do_pass(1'b1, 5, 1, 100, 0, 1'b0);   // full kernel then 5 images
    do_pass(1'b0, 3, 1, 100, 0, 1'b0);   // reuse weights
    do_pass(1'b0, 10, 1, 100, 50, 1'b0); // back-pressure toggling
    do_pass(1'b1, 0, 1, 100, 0, 1'b0);   // load only
    do_pass(1'b0, 0, 1, 100, 0, 1'b0);   // empty pass
    do_pass(1'b1, 4, 3, 100, 0, 1'b0);   // sparse weights
    do_pass(1'b0, 8, 1, 70, 20, 1'b1);   // start pokes while busy
    for (int p = 0; p < 6; p++) begin
      do_pass(1'($urandom), $urandom_range(0, 12), $urandom_range(1, 3),
              $urandom_range(40, 100), $urandom_range(0, 40), 1'b1);
    end

    // Reset with two results in flight.
    start = 1'b1; cfg_reload = 1'b0; cfg_beats = CW'(6);
    step();
    start = 1'b0; up_image_valid = 1'b1;
    step();
    step();
    up_image_valid = 1'b0; rst = 1'b0;
    step();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_result_valid", result_valid, 0);
    check("mid_rst_up_image_ready", up_image_ready, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b1;
    r0 = n_r;
    repeat (8) step();
    check("results_after_rst", n_r - r0, 0);
    $display("reset mid-pass with results in flight");

    do_pass(1'b1, 2, 1, 100, 0, 1'b0);   // clean pass after reset

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
